// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory responder.
// Holds the sequencer state encoding, the host memory-select values and the default depths.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    localparam logic SEL_IMEM = 1'b0;
    localparam logic SEL_DMEM = 1'b1;

    localparam int DEF_IMEM_WORDS = 256;
    localparam int DEF_DMEM_WORDS = 256;
    localparam int DEF_CNT_W      = 32;

    function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned depth);
        return idx < depth;
    endfunction

    // CPU addresses are byte addresses; the low two bits never select anything.
    function automatic logic [31:0] byte_to_word(input logic [31:0] addr);
        return {2'b00, addr[31:2]};
    endfunction

endpackage

// File: rtl/cpu_mem_responder_word_ram.sv
// 32-bit word memory: combinational read, range-checked synchronous write,
// and an optional registered host read port (only the data memory uses it).
module word_ram
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter bit HOST_RD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd_idx,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [31:0] wr_idx,
    input  logic [31:0] wr_data,
    input  logic        host_re,
    input  logic [31:0] host_idx,
    output logic [31:0] host_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    assign rd_data = idx_in_range(rd_idx, DEPTH) ? mem[rd_idx[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (wr_en && idx_in_range(wr_idx, DEPTH)) begin
            mem[wr_idx[AW-1:0]] <= wr_data;
        end
    end

    generate
        if (HOST_RD) begin : g_host_rd
            logic [31:0] host_rdata_q;
            logic [31:0] host_rdata_d;

            always_comb begin
                host_rdata_d = host_rdata_q;
                if (host_re) begin
                    host_rdata_d = idx_in_range(host_idx, DEPTH) ? mem[host_idx[AW-1:0]] : '0;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    host_rdata_q <= '0;
                end else begin
                    host_rdata_q <= host_rdata_d;
                end
            end

            assign host_rdata = host_rdata_q;
        end else begin : g_no_host_rd
            logic unused_host_rd;
            assign unused_host_rd = ^{reset, host_re, host_idx};
            assign host_rdata     = '0;
        end
    endgenerate

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the pipelined CPU: host preload (LOAD), CPU fetch and
// load/store service (RUN), then host readback of data memory (DONE).
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int IMEM_WORDS = DEF_IMEM_WORDS,
    parameter int DMEM_WORDS = DEF_DMEM_WORDS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    output logic [31:0]      instr,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic             cpu_we,
    output logic [31:0]      cpu_rdata,
    input  logic             cpu_halt,
    output logic             start,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic             host_sel,
    input  logic [31:0]      host_addr,
    input  logic [31:0]      host_wdata,
    input  logic             host_last,
    input  logic [31:0]      host_raddr,
    output logic [31:0]      host_rdata,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] run_cycles,
    output logic             addr_err
);

    mem_state_t       state_q, state_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
    logic             addr_err_q, addr_err_d;

    logic [31:0] pc_idx, cpu_idx;
    logic        in_load, in_run, in_done;
    logic        host_xfer, cpu_store, pc_oob, st_oob;
    logic        imem_we, dmem_we;
    logic [31:0] dmem_widx, dmem_wdata;
    logic [31:0] unused_imem_host_rdata;

    assign pc_idx  = byte_to_word(pc);
    assign cpu_idx = byte_to_word(cpu_addr);
    assign in_load = (state_q == ST_LOAD);
    assign in_run  = (state_q == ST_RUN);
    assign in_done = (state_q == ST_DONE);
    assign pc_oob  = !idx_in_range(pc_idx, IMEM_WORDS);
    assign st_oob  = !idx_in_range(cpu_idx, DMEM_WORDS);

    // Host and CPU writes never overlap in time, so one dmem write port is shared.
    assign host_xfer  = in_load && host_valid;
    assign cpu_store  = in_run && cpu_we;
    assign imem_we    = host_xfer && (host_sel == SEL_IMEM);
    assign dmem_we    = (host_xfer && (host_sel == SEL_DMEM)) || cpu_store;
    assign dmem_widx  = in_run ? cpu_idx : host_addr;
    assign dmem_wdata = in_run ? cpu_wdata : host_wdata;

    word_ram #(
        .DEPTH   (IMEM_WORDS),
        .HOST_RD (1'b0)
    ) u_imem (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (pc_idx),
        .rd_data    (instr),
        .wr_en      (imem_we),
        .wr_idx     (host_addr),
        .wr_data    (host_wdata),
        .host_re    (1'b0),
        .host_idx   (32'd0),
        .host_rdata (unused_imem_host_rdata)
    );

    word_ram #(
        .DEPTH   (DMEM_WORDS),
        .HOST_RD (1'b1)
    ) u_dmem (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (cpu_idx),
        .rd_data    (cpu_rdata),
        .wr_en      (dmem_we),
        .wr_idx     (dmem_widx),
        .wr_data    (dmem_wdata),
        .host_re    (in_done),
        .host_idx   (host_raddr),
        .host_rdata (host_rdata)
    );

    always_comb begin
        state_d      = state_q;
        start_d      = 1'b0;
        run_cycles_d = run_cycles_q;
        addr_err_d   = addr_err_q;
        host_ready   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                host_ready = 1'b1;
                if (host_valid && host_last) begin
                    state_d      = ST_RUN;
                    start_d      = 1'b1;
                    run_cycles_d = '0;
                    addr_err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (run_cycles_q != {CNT_W{1'b1}}) begin
                    run_cycles_d = run_cycles_q + CNT_W'(1);
                end
                if (pc_oob || (cpu_we && st_oob)) begin
                    addr_err_d = 1'b1;
                end
                if (cpu_halt) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Leaving DONE is a handshake-free request: nothing is written.
                if (host_valid && host_last) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            start_q      <= 1'b0;
            run_cycles_q <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            run_cycles_q <= run_cycles_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign start      = start_q;
    assign state_o    = state_q;
    assign run_cycles = run_cycles_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: a behavioural model tracks the memories,
// sequencer and counters; host readback goes through a scoreboard queue and monitor.
module tb_cpu_mem_responder;
   import cpu_mem_pkg::*;

   localparam int IW = 256;
   localparam int DW = 256;
   localparam int CW = 32;
   localparam int M_LOAD = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   pc, cpu_addr, cpu_wdata, host_addr, host_wdata, host_raddr;
   logic          cpu_we, cpu_halt, host_valid, host_sel, host_last;
   logic [31:0]   instr, cpu_rdata, host_rdata;
   logic          start, host_ready, addr_err;
   logic [1:0]    state_o;
   logic [CW-1:0] run_cycles;

   cpu_mem_responder #(
      .IMEM_WORDS (IW),
      .DMEM_WORDS (DW),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .instr      (instr),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_we     (cpu_we),
      .cpu_rdata  (cpu_rdata),
      .cpu_halt   (cpu_halt),
      .start      (start),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .host_sel   (host_sel),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_last  (host_last),
      .host_raddr (host_raddr),
      .host_rdata (host_rdata),
      .state_o    (state_o),
      .run_cycles (run_cycles),
      .addr_err   (addr_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] imem_m [IW];
   bit          imem_k [IW];
   logic [31:0] dmem_m [DW];
   bit          dmem_k [DW];
   int          m_state;
   longint unsigned m_cycles;
   bit          m_err;
   bit          m_start;

   logic [31:0] rd_q [$];
   bit          rd_req = 1'b0;
   bit          rd_pend = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Spec-level model of one rising edge, using the inputs currently driven.
   task automatic modelEdge();
      longint unsigned idx;
      m_start = 1'b0;
      case (m_state)
         M_LOAD: begin
            if (host_valid) begin
               if (host_addr < 256) begin
                  if (host_sel) begin
                     dmem_m[host_addr[7:0]] = host_wdata;
                     dmem_k[host_addr[7:0]] = 1'b1;
                  end else begin
                     imem_m[host_addr[7:0]] = host_wdata;
                     imem_k[host_addr[7:0]] = 1'b1;
                  end
               end
               if (host_last) begin
                  m_state  = M_RUN;
                  m_start  = 1'b1;
                  m_cycles = 0;
                  m_err    = 1'b0;
               end
            end
         end
         M_RUN: begin
            idx = longint'(cpu_addr) / 4;
            if (cpu_we) begin
               if (idx < DW) begin
                  dmem_m[idx] = cpu_wdata;
                  dmem_k[idx] = 1'b1;
               end else begin
                  m_err = 1'b1;
               end
            end
            if (longint'(pc) / 4 >= IW) m_err = 1'b1;
            if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
            if (cpu_halt) m_state = M_DONE;
         end
         default: begin
            if (host_valid && host_last) m_state = M_LOAD;
         end
      endcase
   endtask

   task automatic checkReads();
      longint unsigned pi, ci;
      pi = longint'(pc) / 4;
      ci = longint'(cpu_addr) / 4;
      if (pi >= IW) checkOutput("instr oob", instr, 32'h0);
      else if (imem_k[pi]) checkOutput("instr", instr, imem_m[pi]);
      if (ci >= DW) checkOutput("cpu_rdata oob", cpu_rdata, 32'h0);
      else if (dmem_k[ci]) checkOutput("cpu_rdata", cpu_rdata, dmem_m[ci]);
   endtask

   task automatic checkState();
      checkOutput("state_o", 32'(state_o), 32'(m_state));
      checkOutput("start", 32'(start), 32'(m_start));
      checkOutput("run_cycles", run_cycles, m_cycles[31:0]);
      checkOutput("addr_err", 32'(addr_err), 32'(m_err));
      checkOutput("host_ready", 32'(host_ready), 32'(m_state == M_LOAD));
      checkReads();
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      #1;
      checkState();
   endtask

   task automatic applyStimulus(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d,
                                input logic we, input logic halt);
      pc        = p;
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_we    = we;
      cpu_halt  = halt;
      #1;
      checkReads();
   endtask

   task automatic hostBeat(input logic sel, input logic [31:0] a, input logic [31:0] d, input logic last);
      host_valid = 1'b1;
      host_sel   = sel;
      host_addr  = a;
      host_wdata = d;
      host_last  = last;
      #1;
      checkOutput("host_ready beat", 32'(host_ready), 32'(m_state == M_LOAD));
      tick();
      host_valid = 1'b0;
      host_last  = 1'b0;
   endtask

   task automatic hostRead(input logic [31:0] idx);
      host_raddr = idx;
      rd_req     = 1'b1;
      rd_q.push_back((idx < DW) ? dmem_m[idx[7:0]] : 32'h0);
      tick();
      rd_req = 1'b0;
   endtask

   // Registered readback appears one edge after the request.
   always @(posedge clk) rd_pend <= rd_req;

   initial begin
      forever begin
         @(negedge clk);
         if (rd_pend) begin
            if (rd_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL scoreboard underflow: got host_rdata %h with no expectation", host_rdata);
            end else begin
               checkOutput("host_rdata", host_rdata, rd_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [31:0] v;
      reset = 1'b1;
      pc = 0; cpu_addr = 0; cpu_wdata = 0; cpu_we = 0; cpu_halt = 0;
      host_valid = 0; host_sel = 0; host_addr = 0; host_wdata = 0; host_last = 0; host_raddr = 0;
      for (int i = 0; i < IW; i++) imem_k[i] = 1'b0;
      for (int i = 0; i < DW; i++) dmem_k[i] = 1'b0;
      m_state = M_LOAD; m_cycles = 0; m_err = 1'b0; m_start = 1'b0;

      #2;
      $display("[TB] reset state");
      checkOutput("reset state_o", 32'(state_o), 32'(ST_LOAD));
      checkOutput("reset start", 32'(start), 32'h0);
      checkOutput("reset run_cycles", run_cycles, 32'h0);
      checkOutput("reset addr_err", 32'(addr_err), 32'h0);
      checkOutput("reset host_rdata", host_rdata, 32'h0);
      checkOutput("reset host_ready", 32'(host_ready), 32'h1);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] preload");
      hostBeat(SEL_IMEM, 32'd0, 32'hE081_0002, 1'b0);
      for (int i = 1; i < 16; i++) hostBeat(SEL_IMEM, i, $urandom, 1'b0);
      for (int i = 0; i < 16; i++) hostBeat(SEL_DMEM, i, $urandom, 1'b0);
      hostBeat(SEL_DMEM, 32'd44, $urandom, 1'b0);
      hostBeat(SEL_DMEM, 32'd300, 32'hBAD0_BAD0, 1'b0);
      hostBeat(SEL_IMEM, 32'd260, 32'hBAD1_BAD1, 1'b0);
      hostBeat(SEL_DMEM, 32'd3, 32'h0000_002A, 1'b1);
      checkOutput("start in first RUN cycle", 32'(start), 32'h1);
      tick();
      checkOutput("start drops", 32'(start), 32'h0);

      $display("[TB] run: fetch, store, load");
      applyStimulus(32'h0, 32'd44 * 4, 32'h0, 1'b0, 1'b0);
      checkOutput("instr pc=0", instr, 32'hE081_0002);
      applyStimulus(32'h4, 32'h0C, 32'h1234_5678, 1'b1, 1'b0);
      tick();
      applyStimulus(32'h8, 32'h0C, 32'h0, 1'b0, 1'b0);
      checkOutput("load 0x0C", cpu_rdata, 32'h1234_5678);
      applyStimulus(32'h8, 32'h0E, 32'h0, 1'b0, 1'b0);
      checkOutput("load 0x0E", cpu_rdata, 32'h1234_5678);
      for (int i = 0; i < 6; i++) begin
         applyStimulus($urandom_range(0, 63), $urandom_range(0, 127), $urandom, 1'b1, 1'b0);
         tick();
         applyStimulus($urandom_range(0, 63), $urandom_range(0, 63), 32'h0, 1'b0, 1'b0);
      end

      $display("[TB] out-of-range store");
      applyStimulus(32'h0, 32'h400, 32'hDEAD_BEEF, 1'b1, 1'b0);
      tick();
      applyStimulus(32'h0, 32'h400, 32'h0, 1'b0, 1'b0);
      checkOutput("oob load", cpu_rdata, 32'h0);
      applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      checkOutput("addr_err sticky", 32'(addr_err), 32'h1);

      $display("[TB] halt with store");
      applyStimulus(32'h0, 32'h0C, 32'h7, 1'b1, 1'b1);
      tick();
      applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("state DONE", 32'(state_o), 32'(ST_DONE));

      $display("[TB] readback");
      host_valid = 1'b1; host_sel = SEL_DMEM; host_addr = 32'd3; host_wdata = 32'hDEAD_0000; host_last = 1'b0;
      #1;
      checkOutput("host_ready in DONE", 32'(host_ready), 32'h0);
      applyStimulus(32'h0, 32'h10, 32'hCAFE_F00D, 1'b1, 1'b0);
      tick();
      host_valid = 1'b0;
      applyStimulus(32'h0, 32'h10, 32'h0, 1'b0, 1'b0);
      hostRead(32'd3);
      hostRead(32'd44);
      hostRead(32'd999);
      for (int i = 0; i < 8; i++) hostRead($urandom_range(0, 15));

      $display("[TB] rerun");
      host_valid = 1'b1; host_last = 1'b1;
      tick();
      host_valid = 1'b0; host_last = 1'b0;
      checkOutput("addr_err held in LOAD", 32'(addr_err), 32'h1);
      hostBeat(SEL_IMEM, 32'd1, $urandom, 1'b1);
      checkOutput("run_cycles cleared", run_cycles, 32'h0);
      checkOutput("addr_err cleared", 32'(addr_err), 32'h0);
      applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("halt in start cycle", 32'(state_o), 32'(ST_DONE));

      $display("[TB] pc out of range, reset mid-run");
      host_valid = 1'b1; host_last = 1'b1;
      tick();
      host_valid = 1'b0; host_last = 1'b0;
      hostBeat(SEL_DMEM, 32'd5, $urandom, 1'b1);
      applyStimulus(32'h800, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("run_cycles before reset", run_cycles, 32'd5);
      #2;
      reset = 1'b1;
      #1;
      m_state = M_LOAD; m_cycles = 0; m_err = 1'b0; m_start = 1'b0;
      checkOutput("async reset state_o", 32'(state_o), 32'(ST_LOAD));
      checkOutput("async reset start", 32'(start), 32'h0);
      checkOutput("async reset run_cycles", run_cycles, 32'h0);
      checkOutput("async reset addr_err", 32'(addr_err), 32'h0);
      checkOutput("async reset host_rdata", host_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      v = imem_m[0];
      applyStimulus(32'h0, 32'h0C, 32'h0, 1'b0, 1'b0);
      checkOutput("imem kept over reset", instr, v);
      tick();

      checkOutput("scoreboard drained", 32'(rd_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
